// File: rtl/ex_pkg.sv
// Shared definitions for the execution dispatch stage: default widths and the
// dispatch payload layout for the default configuration.
package ex_pkg;

  localparam int EX_NUM_FU   = 3;
  localparam int EX_XLEN     = 32;
  localparam int EX_ROB_BITS = 5;
  localparam int EX_PRF_BITS = 6;
  localparam int EX_OPC_BITS = 7;
  localparam int EX_CNT_BITS = 32;

  typedef struct packed {
    logic [EX_XLEN-1:0]     a;
    logic [EX_XLEN-1:0]     b;
    logic [EX_OPC_BITS-1:0] opc;
    logic [EX_ROB_BITS-1:0] rob;
    logic [EX_PRF_BITS-1:0] dest;
    logic                   dest_vld;
    logic [EX_NUM_FU-1:0]   sel;
  } ex_disp_payload_t;

endpackage

// File: rtl/ex_skid_reg.sv
// Two-entry valid/ready skid register: the main entry drives the consumer, the
// skid entry absorbs one op accepted while main is stalled.
module ex_skid_reg #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output logic main_valid_o,
  output T     main_data_o,
  output logic skid_full_o,
  output logic load_main_o,
  output T     load_data_o
);

  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  T     main_q, main_d;
  T     skid_q, skid_d;
  logic main_free;

  // load_main_o marks the edge on which an op enters main, whatever its source.
  always_comb begin
    main_free    = !main_valid_q || pop_i;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    load_main_o  = 1'b0;
    load_data_o  = skid_valid_q ? skid_q : push_data_i;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q || push_i) begin
        load_main_o  = 1'b1;
        main_valid_d = 1'b1;
        main_d       = load_data_o;
        skid_valid_d = skid_valid_q && push_i;
        if (skid_valid_q && push_i) skid_d = push_data_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (push_i) begin
      skid_valid_d = 1'b1;
      skid_d       = push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign main_valid_o = main_valid_q;
  assign main_data_o  = main_q;
  assign skid_full_o  = skid_valid_q;

endmodule

// File: rtl/ex_dispatch_stage.sv
// Registered operand dispatch to NUM_FU execution units with skid backpressure,
// one-shot wakeup, illegal FU-select detection and a saturating stall counter.
module ex_dispatch_stage
  import ex_pkg::*;
#(
  parameter int NUM_FU   = EX_NUM_FU,
  parameter int XLEN     = EX_XLEN,
  parameter int ROB_BITS = EX_ROB_BITS,
  parameter int PRF_BITS = EX_PRF_BITS,
  parameter int OPC_BITS = EX_OPC_BITS,
  parameter int CNT_BITS = EX_CNT_BITS
) (
  input  logic                cpu_clock_i,
  input  logic                cpu_resetn_i,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [NUM_FU-1:0]   in_fu_sel_i,
  input  logic [OPC_BITS-1:0] in_opc_i,
  input  logic [XLEN-1:0]     in_rs1_data_i,
  input  logic [XLEN-1:0]     in_rs2_data_i,
  input  logic [XLEN-1:0]     in_imm_i,
  input  logic                in_use_imm_i,
  input  logic                in_zero_a_i,
  input  logic [ROB_BITS-1:0] in_rob_i,
  input  logic [PRF_BITS-1:0] in_dest_i,
  input  logic                in_dest_vld_i,
  output logic [NUM_FU-1:0]   fu_valid_o,
  input  logic [NUM_FU-1:0]   fu_ready_i,
  output logic [XLEN-1:0]     fu_a_o,
  output logic [XLEN-1:0]     fu_b_o,
  output logic [OPC_BITS-1:0] fu_opc_o,
  output logic [ROB_BITS-1:0] fu_rob_o,
  output logic [PRF_BITS-1:0] fu_dest_o,
  output logic                wakeup_valid_o,
  output logic [PRF_BITS-1:0] wakeup_dest_o,
  output logic                illegal_sel_o,
  output logic [CNT_BITS-1:0] stall_cnt_o
);

  // Same layout as ex_disp_payload_t, sized from this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic [OPC_BITS-1:0] opc;
    logic [ROB_BITS-1:0] rob;
    logic [PRF_BITS-1:0] dest;
    logic                dest_vld;
    logic [NUM_FU-1:0]   sel;
  } payload_t;

  payload_t in_pl, main_pl, load_pl;
  logic     main_valid, skid_full, load_main;
  logic     accept, sel_legal, push, transfer, stall;

  logic                wakeup_valid_q, wakeup_valid_d;
  logic [PRF_BITS-1:0] wakeup_dest_q, wakeup_dest_d;
  logic                illegal_q, illegal_d;
  logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

  assign in_ready_o = !skid_full;
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign sel_legal  = ($countones(in_fu_sel_i) == 1);
  assign push       = accept && sel_legal;
  assign transfer   = |(fu_valid_o & fu_ready_i);
  assign stall      = main_valid && !transfer;

  always_comb begin
    in_pl          = '0;
    in_pl.a        = in_zero_a_i ? '0 : in_rs1_data_i;
    in_pl.b        = (in_use_imm_i || in_zero_a_i) ? in_imm_i : in_rs2_data_i;
    in_pl.opc      = in_zero_a_i ? '0 : in_opc_i;
    in_pl.rob      = in_rob_i;
    in_pl.dest     = in_dest_i;
    in_pl.dest_vld = in_dest_vld_i;
    in_pl.sel      = in_fu_sel_i;
  end

  ex_skid_reg #(.T(payload_t)) u_skid (
    .clk_i        (cpu_clock_i),
    .rst_ni       (cpu_resetn_i),
    .flush_i      (flush_i),
    .push_i       (push),
    .push_data_i  (in_pl),
    .pop_i        (transfer),
    .main_valid_o (main_valid),
    .main_data_o  (main_pl),
    .skid_full_o  (skid_full),
    .load_main_o  (load_main),
    .load_data_o  (load_pl)
  );

  always_comb begin
    wakeup_valid_d = load_main && load_pl.dest_vld;
    wakeup_dest_d  = load_main ? load_pl.dest : wakeup_dest_q;
    illegal_d      = accept && !sel_legal;
    stall_cnt_d    = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      wakeup_valid_q <= 1'b0;
      wakeup_dest_q  <= '0;
      illegal_q      <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      wakeup_valid_q <= wakeup_valid_d;
      wakeup_dest_q  <= wakeup_dest_d;
      illegal_q      <= illegal_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign fu_valid_o     = main_valid ? main_pl.sel : '0;
  assign fu_a_o         = main_pl.a;
  assign fu_b_o         = main_pl.b;
  assign fu_opc_o       = main_pl.opc;
  assign fu_rob_o       = main_pl.rob;
  assign fu_dest_o      = main_pl.dest;
  assign wakeup_valid_o = wakeup_valid_q;
  assign wakeup_dest_o  = wakeup_dest_q;
  assign illegal_sel_o  = illegal_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_ex_dispatch_stage.sv
// Directed bench for ex_dispatch_stage: default instance plus a 4-bit stall
// counter instance sharing the same stimulus.
module tb_ex_dispatch_stage;

  logic        clk, rst_n, flush, in_valid;
  logic [2:0]  in_sel, fu_ready;
  logic [6:0]  in_opc;
  logic [31:0] in_rs1, in_rs2, in_imm;
  logic        in_use_imm, in_zero_a, in_dest_vld;
  logic [4:0]  in_rob;
  logic [5:0]  in_dest;

  logic        in_ready, wk_valid, illegal;
  logic [2:0]  fu_valid;
  logic [31:0] fu_a, fu_b, stall_cnt;
  logic [6:0]  fu_opc;
  logic [4:0]  fu_rob;
  logic [5:0]  fu_dest, wk_dest;

  logic        s_in_ready, s_wk_valid, s_illegal;
  logic [2:0]  s_fu_valid;
  logic [31:0] s_fu_a, s_fu_b;
  logic [6:0]  s_fu_opc;
  logic [4:0]  s_fu_rob;
  logic [5:0]  s_fu_dest, s_wk_dest;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int failures = 0;

  ex_dispatch_stage dut (
    .cpu_clock_i(clk), .cpu_resetn_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_fu_sel_i(in_sel),
    .in_opc_i(in_opc), .in_rs1_data_i(in_rs1), .in_rs2_data_i(in_rs2),
    .in_imm_i(in_imm), .in_use_imm_i(in_use_imm), .in_zero_a_i(in_zero_a),
    .in_rob_i(in_rob), .in_dest_i(in_dest), .in_dest_vld_i(in_dest_vld),
    .fu_valid_o(fu_valid), .fu_ready_i(fu_ready), .fu_a_o(fu_a), .fu_b_o(fu_b),
    .fu_opc_o(fu_opc), .fu_rob_o(fu_rob), .fu_dest_o(fu_dest),
    .wakeup_valid_o(wk_valid), .wakeup_dest_o(wk_dest),
    .illegal_sel_o(illegal), .stall_cnt_o(stall_cnt)
  );

  ex_dispatch_stage #(.CNT_BITS(4)) dut_sat (
    .cpu_clock_i(clk), .cpu_resetn_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(s_in_ready), .in_fu_sel_i(in_sel),
    .in_opc_i(in_opc), .in_rs1_data_i(in_rs1), .in_rs2_data_i(in_rs2),
    .in_imm_i(in_imm), .in_use_imm_i(in_use_imm), .in_zero_a_i(in_zero_a),
    .in_rob_i(in_rob), .in_dest_i(in_dest), .in_dest_vld_i(in_dest_vld),
    .fu_valid_o(s_fu_valid), .fu_ready_i(fu_ready), .fu_a_o(s_fu_a), .fu_b_o(s_fu_b),
    .fu_opc_o(s_fu_opc), .fu_rob_o(s_fu_rob), .fu_dest_o(s_fu_dest),
    .wakeup_valid_o(s_wk_valid), .wakeup_dest_o(s_wk_dest),
    .illegal_sel_o(s_illegal), .stall_cnt_o(s_stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] sel, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic use_imm, input logic zero_a,
                          input logic [6:0] opc, input logic [5:0] dest, input logic dest_vld);
    in_valid    = 1'b1;
    in_sel      = sel;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_imm      = imm;
    in_use_imm  = use_imm;
    in_zero_a   = zero_a;
    in_opc      = opc;
    in_rob      = dest[4:0];
    in_dest     = dest;
    in_dest_vld = dest_vld;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = '0; fu_ready = '0;
    in_opc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_use_imm = 1'b0;
    in_zero_a = 1'b0; in_rob = '0; in_dest = '0; in_dest_vld = 1'b0;
    #12;
    check("rst_fu_valid", fu_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_wakeup", wk_valid, 0);
    check("rst_illegal", illegal, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_fu_a", fu_a, 0);
    #1 rst_n = 1'b1;
    tick();

    // 1: single op, ready FUs
    fu_ready = 3'b111;
    drive_op(3'b001, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 7'h33, 6'd9, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t1_fu_valid", fu_valid, 3'b001);
    check("t1_a", fu_a, 5);
    check("t1_b", fu_b, 7);
    check("t1_opc", fu_opc, 7'h33);
    check("t1_wk_valid", wk_valid, 1);
    check("t1_wk_dest", wk_dest, 9);
    tick();
    check("t1_drained", fu_valid, 0);
    check("t1_wk_once", wk_valid, 0);
    check("t1_stall", stall_cnt, 0);

    // 2: backpressure into skid, then drain in order
    fu_ready = 3'b000;
    drive_op(3'b100, 32'd100, 32'd1, 32'd0, 1'b0, 1'b0, 7'h01, 6'd10, 1'b1);
    tick();
    check("t2_op0_wk", wk_dest, 10);
    drive_op(3'b010, 32'd200, 32'd2, 32'd0, 1'b0, 1'b0, 7'h02, 6'd11, 1'b1);
    tick();
    drive_op(3'b001, 32'd300, 32'd3, 32'd0, 1'b0, 1'b0, 7'h03, 6'd12, 1'b0);
    check("t2_in_ready_low", in_ready, 0);
    check("t2_main_op0", fu_a, 100);
    check("t2_fu_valid", fu_valid, 3'b100);
    check("t2_skid_no_wk", wk_valid, 0);
    tick();
    check("t2_hold_a", fu_a, 100);
    check("t2_stall2", stall_cnt, 2);
    fu_ready = 3'b111;
    tick();
    check("t2_main_op1", fu_a, 200);
    check("t2_sel_op1", fu_valid, 3'b010);
    check("t2_op1_wk", wk_dest, 11);
    check("t2_op1_wk_v", wk_valid, 1);
    check("t2_in_ready_up", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t2_main_op2", fu_a, 300);
    check("t2_op2_no_wk", wk_valid, 0);
    tick();
    check("t2_empty", fu_valid, 0);
    check("t2_stall_final", stall_cnt, 2);

    // 3: operand muxing
    drive_op(3'b010, 32'hFFFF_FFFF, 32'hDEAD, 32'h1234_5000, 1'b0, 1'b1, 7'h37, 6'd20, 1'b1);
    tick();
    check("t3_lui_a", fu_a, 0);
    check("t3_lui_b", fu_b, 32'h1234_5000);
    check("t3_lui_opc", fu_opc, 0);
    drive_op(3'b001, 32'd3, 32'hBEEF, 32'h55, 1'b1, 1'b0, 7'h13, 6'd21, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t3_imm_a", fu_a, 3);
    check("t3_imm_b", fu_b, 32'h55);
    check("t3_imm_opc", fu_opc, 7'h13);
    tick();

    // 4: illegal select
    drive_op(3'b011, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 7'h01, 6'd30, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t4_no_valid", fu_valid, 0);
    check("t4_no_wk", wk_valid, 0);
    check("t4_illegal", illegal, 1);
    check("t4_ready", in_ready, 1);
    tick();
    check("t4_illegal_pulse", illegal, 0);

    // 5: flush with main and skid full
    fu_ready = 3'b000;
    drive_op(3'b001, 32'd40, 32'd0, 32'd0, 1'b0, 1'b0, 7'h01, 6'd40, 1'b0);
    tick();
    drive_op(3'b010, 32'd41, 32'd0, 32'd0, 1'b0, 1'b0, 7'h01, 6'd41, 1'b0);
    tick();
    check("t5_full", in_ready, 0);
    drive_op(3'b100, 32'd42, 32'd0, 32'd0, 1'b0, 1'b0, 7'h01, 6'd42, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t5_fu_valid", fu_valid, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_no_wk", wk_valid, 0);
    check("t5_stall_kept", stall_cnt, 4);
    tick();
    check("t5_still_empty", fu_valid, 0);
    check("t5_still_no_wk", wk_valid, 0);

    // 6: saturation on the 4-bit counter, then async reset mid-stall
    drive_op(3'b001, 32'd50, 32'd0, 32'd0, 1'b0, 1'b0, 7'h01, 6'd50, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("t6_sat", s_stall_cnt, 15);
    check("t6_wide", stall_cnt, 24);
    tick();
    check("t6_sat_held", s_stall_cnt, 15);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", fu_valid, 0);
    check("t6_rst_ready", in_ready, 1);
    check("t6_rst_cnt", stall_cnt, 0);
    check("t6_rst_sat_cnt", s_stall_cnt, 0);
    check("t6_rst_sat_valid", s_fu_valid, 0);
    check("t6_rst_a", fu_a, 0);
    #2 rst_n = 1'b1;
    tick();
    check("t6_post_valid", fu_valid, 0);
    check("t6_post_cnt", stall_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
